// File: rtl/hash_mem_pkg.sv
// Shared types and constants for the hash memory responder slice.
package hash_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    COMPLETE
  } mon_state_t;

  localparam logic [31:0] POISON_WORD    = 32'hDEADBEEF;
  localparam logic [31:0] MIN_INIT       = 32'hFFFFFFFF;
  localparam int unsigned DEF_DEPTH      = 1024;
  localparam int unsigned DEF_NUM_NONCES = 16;

endpackage

// File: rtl/hash_mem_responder_if.sv
// Hasher memory port plus host load/readback port of the hash memory responder.
interface hash_mem_responder_if;

  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        hasher_busy;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_ack;

  modport master (
    output mem_we, mem_addr, mem_write_data, hasher_busy,
    output host_req, host_we, host_addr, host_wdata,
    input  mem_read_data, host_rdata, host_ack
  );

  modport slave (
    input  mem_we, mem_addr, mem_write_data, hasher_busy,
    input  host_req, host_we, host_addr, host_wdata,
    output mem_read_data, host_rdata, host_ack
  );

endinterface

// File: rtl/hash_result_monitor.sv
// Watches hasher writes into the result window, tracks which nonces have
// reported and keeps the smallest result word (ties go to the lower nonce).
module hash_result_monitor
  import hash_mem_pkg::*;
#(
  parameter int unsigned NUM_NONCES = DEF_NUM_NONCES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        arm,
  input  logic [15:0] out_base,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        results_valid,
  output logic [31:0] min_hash,
  output logic [3:0]  min_idx
);

  localparam int unsigned IW = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;

  mon_state_t            state_q, state_d;
  logic [15:0]           base_q;
  logic [15:0]           offset;
  logic [IW-1:0]         off_w;
  logic [NUM_NONCES-1:0] mask_q, mask_d;
  logic                  hit;
  logic                  better;

  // Unsigned wrap makes addresses below the base land far outside the window.
  assign offset = wr_addr - base_q;
  assign off_w  = offset[IW-1:0];
  assign hit    = (state_q == COLLECT) && wr_en && ({16'h0, offset} < NUM_NONCES);
  assign better = (wr_data < min_hash) ||
                  ((wr_data == min_hash) && (4'(off_w) < min_idx));

  // Mask as it will be after this cycle's write
  always_comb begin
    mask_d = mask_q;
    if (hit) mask_d[off_w] = 1'b1;
  end

  // Monitor state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: arm restarts from anywhere, full mask completes collection
  always_comb begin
    state_d = state_q;
    if (arm)                                    state_d = COLLECT;
    else if ((state_q == COLLECT) && (&mask_d)) state_d = COMPLETE;
  end

  // Window base, nonce mask and running minimum
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q   <= '0;
      mask_q   <= '0;
      min_hash <= MIN_INIT;
      min_idx  <= '0;
    end else if (arm) begin
      base_q   <= out_base;
      mask_q   <= '0;
      min_hash <= MIN_INIT;
      min_idx  <= '0;
    end else if (hit) begin
      mask_q <= mask_d;
      if (better) begin
        min_hash <= wr_data;
        min_idx  <= 4'(off_w);
      end
    end
  end

  // Outputs decoded from state
  always_comb begin
    results_valid = (state_q == COMPLETE);
  end

endmodule

// File: rtl/hash_mem_responder.sv
// Word memory behind the hasher's single-port interface, with an idle-time
// host port and a result-window monitor.
// Optional: define HASH_MEM_OOR_CHECK_EN to block/poison out-of-range
// accesses and raise a sticky err; otherwise addresses wrap modulo DEPTH.
module hash_mem_responder
  import hash_mem_pkg::*;
#(
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned NUM_NONCES = DEF_NUM_NONCES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  hash_mem_responder_if.slave  bus,
  input  logic                 arm,
  input  logic [15:0]          out_base,
  output logic                 results_valid,
  output logic [31:0]          min_hash,
  output logic [3:0]           min_idx,
  output logic                 err
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   ram [DEPTH];
  logic [AW-1:0] hash_a, host_a;
  logic          hash_oor, host_oor;
  logic          host_go;
  logic          hash_wr, host_wr;

  // Host is served only on an idle hasher cycle with no hasher write, and
  // never on the cycle its previous ack is showing (one access per two cycles).
  assign host_go = bus.host_req && !bus.hasher_busy && !bus.mem_we && !bus.host_ack;
  assign hash_a  = bus.mem_addr[AW-1:0];
  assign host_a  = bus.host_addr[AW-1:0];

`ifdef HASH_MEM_OOR_CHECK_EN
  assign hash_oor = ({16'h0, bus.mem_addr}  >= 32'(DEPTH));
  assign host_oor = ({16'h0, bus.host_addr} >= 32'(DEPTH));
`else
  logic unused_host_addr_hi;
  assign hash_oor            = 1'b0;
  assign host_oor            = 1'b0;
  assign unused_host_addr_hi = ^bus.host_addr;
`endif

  // Writes are gated by reset so an access cut by reset never lands
  assign hash_wr = bus.mem_we && !hash_oor && reset_n;
  assign host_wr = host_go && bus.host_we && !host_oor && reset_n;

  // RAM array, uninitialised; the hasher write takes precedence
  always_ff @(posedge clk) begin
    if (hash_wr)      ram[hash_a] <= bus.mem_write_data;
    else if (host_wr) ram[host_a] <= bus.host_wdata;
  end

  // Registered read data for both ports and the host completion pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_read_data <= '0;
      bus.host_rdata    <= '0;
      bus.host_ack      <= 1'b0;
    end else begin
      bus.mem_read_data <= hash_oor ? POISON_WORD : ram[hash_a];
      bus.host_ack      <= host_go;
      if (host_go && !bus.host_we)
        bus.host_rdata <= host_oor ? POISON_WORD : ram[host_a];
    end
  end

`ifdef HASH_MEM_OOR_CHECK_EN
  // Sticky flag for any out-of-range write or serviced host access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err <= 1'b0;
    else if ((bus.mem_we && hash_oor) || (host_go && host_oor)) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  hash_result_monitor #(
    .NUM_NONCES (NUM_NONCES)
  ) u_monitor (
    .clk           (clk),
    .reset_n       (reset_n),
    .arm           (arm),
    .out_base      (out_base),
    .wr_en         (bus.mem_we),
    .wr_addr       (bus.mem_addr),
    .wr_data       (bus.mem_write_data),
    .results_valid (results_valid),
    .min_hash      (min_hash),
    .min_idx       (min_idx)
  );

endmodule

// File: tb/tb_hash_mem_responder.sv
// Directed + randomized bench for hash_mem_responder against a memory map
// and result-window model.
module tb_hash_mem_responder;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        arm = 1'b0;
  logic [15:0] out_base = '0;
  logic        results_valid;
  logic [31:0] min_hash;
  logic [3:0]  min_idx;
  logic        err;

  hash_mem_responder_if bus ();

  hash_mem_responder #(
    .DEPTH      (DEPTH),
    .NUM_NONCES (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .arm           (arm),
    .out_base      (out_base),
    .results_valid (results_valid),
    .min_hash      (min_hash),
    .min_idx       (min_idx),
    .err           (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: memory contents, and the set of (value, nonce) reports since arm
  logic [31:0] m_ram [int];
  int          m_state = 0;   // 0 idle, 1 collecting, 2 complete
  logic [15:0] m_base  = '0;
  bit   [15:0] m_seen  = '0;
  logic [35:0] m_keys [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int phys(input logic [15:0] a);
    return int'(a) % DEPTH;
  endfunction

  function automatic bit is_oor(input logic [15:0] a);
`ifdef HASH_MEM_OOR_CHECK_EN
    return int'(a) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] rd_exp(input logic [15:0] a);
    if (is_oor(a)) return 32'hDEADBEEF;
    return m_ram[phys(a)];
  endfunction

  function automatic void mon_write(input logic [15:0] a, input logic [31:0] d);
    logic [15:0] off;
    off = a - m_base;
    if (m_state == 1 && off < 16) begin
      m_keys.push_back({d, off[3:0]});
      m_seen[off[3:0]] = 1'b1;
      if (&m_seen) m_state = 2;
    end
  endfunction

  // Smallest (value, nonce) pair, starting from the empty-window default
  function automatic logic [35:0] mon_min();
    logic [35:0] k;
    k = {32'hFFFFFFFF, 4'h0};
    foreach (m_keys[i]) if (m_keys[i] < k) k = m_keys[i];
    return k;
  endfunction

  task automatic chk_mon(input string tag);
    logic [35:0] k;
    k = mon_min();
    chk({tag, "_valid"}, results_valid, (m_state == 2));
    chk({tag, "_min"}, min_hash, k[35:4]);
    chk({tag, "_idx"}, min_idx, k[3:0]);
  endtask

  task automatic hw(input logic [15:0] a, input logic [31:0] d);
    bus.mem_we = 1'b1; bus.mem_addr = a; bus.mem_write_data = d;
    tick();
    bus.mem_we = 1'b0;
    if (!is_oor(a)) m_ram[phys(a)] = d;
    mon_write(a, d);
  endtask

  task automatic hread(input string tag, input logic [15:0] a);
    bus.mem_addr = a;
    tick();
    chk(tag, bus.mem_read_data, rd_exp(a));
  endtask

  task automatic host(input string tag, input bit we, input logic [15:0] a, input logic [31:0] d);
    bit got;
    got = 1'b0;
    bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (bus.host_ack === 1'b1) got = 1'b1;
    end
    bus.host_req = 1'b0;
    chk({tag, "_ack"}, 32'(got), 32'd1);
    if (got) begin
      if (we) begin
        if (!is_oor(a)) m_ram[phys(a)] = d;
      end else begin
        chk({tag, "_rd"}, bus.host_rdata, rd_exp(a));
      end
    end
    tick();
  endtask

  task automatic do_arm(input logic [15:0] b);
    arm = 1'b1; out_base = b;
    tick();
    arm = 1'b0;
    m_state = 1; m_base = b; m_seen = '0; m_keys.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mrd"}, bus.mem_read_data, 32'h0);
    chk({tag, "_hrd"}, bus.host_rdata, 32'h0);
    chk({tag, "_ack"}, bus.host_ack, 32'h0);
    chk({tag, "_valid"}, results_valid, 32'h0);
    chk({tag, "_min"}, min_hash, 32'hFFFFFFFF);
    chk({tag, "_idx"}, min_idx, 32'h0);
    chk({tag, "_err"}, err, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b;
    logic [31:0] d1, d2, t, v6;

    bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_write_data = '0; bus.hasher_busy = 1'b0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;

    // Reset values
    tick(); tick();
    chk_reset("rst");
    reset_n = 1'b1;
    tick();

    // Read latency: one cycle from address to data
    v6 = 32'hA5A50006;
    host("ld6", 1'b1, 16'd6, v6);
    host("ld5", 1'b1, 16'd5, 32'h12345678);
    hread("lat_pre", 16'd6);
    bus.mem_addr = 16'd5;
    #3;
    chk("lat_prev", bus.mem_read_data, v6);
    @(posedge clk); #1;
    chk("lat_new", bus.mem_read_data, 32'h12345678);

    // Arbitration against hasher_busy, back-to-back acks on a held request
    d1 = $urandom;
    host("ld3", 1'b1, 16'd3, d1);
    bus.hasher_busy = 1'b1;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 16'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("busy_noack", bus.host_ack, 32'h0);
    end
    bus.hasher_busy = 1'b0;
    tick();
    chk("arb_ack1", bus.host_ack, 32'h1);
    chk("arb_rd", bus.host_rdata, d1);
    tick();
    chk("arb_gap", bus.host_ack, 32'h0);
    tick();
    chk("arb_ack2", bus.host_ack, 32'h1);
    bus.host_req = 1'b0;
    tick();
    chk("arb_drop", bus.host_ack, 32'h0);

    // Hasher write wins over a simultaneous host write
    d1 = $urandom; d2 = $urandom;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 16'd8; bus.host_wdata = d1;
    bus.mem_we = 1'b1; bus.mem_addr = 16'd9; bus.mem_write_data = d2;
    tick();
    chk("conf_wait", bus.host_ack, 32'h0);
    bus.mem_we = 1'b0;
    m_ram[9] = d2;
    tick();
    chk("conf_ack", bus.host_ack, 32'h1);
    bus.host_req = 1'b0;
    m_ram[8] = d1;
    tick();
    hread("conf_rd8", 16'd8);
    hread("conf_rd9", 16'd9);

    // Random load/readback across both ports, including read-during-write
    for (int i = 0; i < 6; i++) begin
      a  = 16'($urandom_range(0, DEPTH - 1));
      d1 = $urandom; d2 = $urandom;
      host("rnd_ld", 1'b1, a, d1);
      hread("rnd_hrd", a);
      hw(a, d2);
      chk("rnd_rdw_old", bus.mem_read_data, d1);
      host("rnd_back", 1'b0, a, 32'h0);
    end

    // Result window: offsets 15..0, offset 7 holds the minimum
    do_arm(16'h0100);
    for (int i = 15; i >= 0; i--) begin
      d1 = (i == 7) ? 32'h1 : (32'(16 - i) << 20);
      hw(16'h0100 + 16'(i), d1);
      if (i == 1) chk_mon("res_partial");
    end
    chk_mon("res_done");
    chk("res_min_const", min_hash, 32'h1);
    chk("res_idx_const", min_idx, 32'd7);
    hw(16'h0103, 32'h0);
    chk_mon("res_hold");

    // arm while complete clears everything
    do_arm(16'h0200);
    chk_mon("rearm");
    chk("rearm_valid", results_valid, 32'h0);
    chk("rearm_min", min_hash, 32'hFFFFFFFF);

    // Duplicates and ties: offset 2 twice, offset 11 late, equal minima at 9 then 4
    b = 16'($urandom_range(16, 900));
    t = 32'($urandom_range(1, 255));
    do_arm(b);
    hw(b + 16'd9, t);
    hw(b + 16'd2, 32'h00010000 | $urandom);
    hw(b + 16'd2, 32'h00010000 | $urandom);
    for (int i = 0; i < 16; i++) begin
      if (i == 2 || i == 9 || i == 11) continue;
      hw(b + 16'(i), (i == 4) ? t : (32'h00010000 | $urandom));
    end
    chk_mon("dup_wait");
    chk("tie_idx", min_idx, 32'd4);
    hw(b + 16'd11, 32'h00010000 | $urandom);
    chk_mon("dup_done");

    // Window edges do not count
    b = 16'($urandom_range(1, 900));
    do_arm(b);
    hw(b - 16'd1, 32'h0);
    hw(b + 16'd16, 32'h0);
    chk_mon("edge");
    chk("edge_min", min_hash, 32'hFFFFFFFF);
    for (int i = 0; i < 15; i++) hw(b + 16'(i), 32'h00000100 | $urandom);
    chk_mon("edge_15");
    hw(b + 16'd15, $urandom);
    chk_mon("edge_16");

    // Reset during collection
    b = 16'($urandom_range(0, 900));
    do_arm(b);
    hw(b, 32'h5); hw(b + 16'd1, 32'h3); hw(b + 16'd2, 32'h7);
    chk_mon("pre_rst");
    reset_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    tick();
    reset_n = 1'b1;
    m_state = 0; m_seen = '0; m_keys.delete();
    tick();
    hw(b + 16'd3, 32'h0);
    chk_mon("post_rst_idle");
    hread("post_rst_ram", b + 16'd1);

    // Out-of-range handling
    host("ld_top", 1'b1, 16'(DEPTH - 1), 32'h0BADF00D);
    hw(16'hFFFF, 32'h11111111);
`ifdef HASH_MEM_OOR_CHECK_EN
    chk("oor_err", err, 32'h1);
    host("oor_host", 1'b0, 16'h8000, 32'h0);
`else
    chk("oor_err0", err, 32'h0);
`endif
    hread("oor_top", 16'(DEPTH - 1));
    hread("oor_ffff", 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
